pcie_csr_responder: RTL

PCIE_CSR_RESPONDER -- requirements
Module: pcie_csr_responder

---
 rtl/pcie_csr_responder_pkg.sv | 46 ++++
 rtl/pcie_csr_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_csr_responder_pkg.sv
// Shared constants, response codes and FSM state types for the PCIe feature CSR responder.
package pcie_csr_responder_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = 2;

  localparam int unsigned OFF_DFH        = 32'h00;
  localparam int unsigned OFF_SCRATCHPAD = 32'h08;
  localparam int unsigned OFF_STAT       = 32'h10;
  localparam int unsigned OFF_ERROR_MASK = 32'h18;
  localparam int unsigned OFF_ERROR      = 32'h20;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DFH,
    SEL_SCRATCHPAD,
    SEL_STAT,
    SEL_ERROR_MASK,
    SEL_ERROR
  } reg_sel_e;

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/pcie_csr_responder.sv
// AXI-lite style CSR responder for a feature window: DFH, scratchpad, status and
// sticky error registers with independent read and write channels.
module pcie_csr_responder
  import pcie_csr_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [63:0] DFH_VALUE = 64'h3000000010000020,
  parameter int unsigned ERR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  input  logic [63:0]       stat_in,
  input  logic [ERR_W-1:0]  err_in,
  output logic              err_irq
);

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [63:0]       scratch_q, scratch_d;
  logic [63:0]       stat_q, stat_d;
  logic [63:0]       mask_q, mask_d;
  logic [ERR_W-1:0]  error_q, error_d;
  logic              err_irq_q, err_irq_d;

  logic              wr_fire_c;
  logic              wr_misaligned_c;
  reg_sel_e          wr_sel_c;
  logic [63:0]       wr_bitmask_c;
  logic [ERR_W-1:0]  err_clr_c;
  logic              rd_fire_c;
  logic              rd_misaligned_c;
  reg_sel_e          rd_sel_c;
  logic [63:0]       rd_value_c;

  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == ADDR_W'(OFF_DFH))             sel = SEL_DFH;
    else if (addr == ADDR_W'(OFF_SCRATCHPAD)) sel = SEL_SCRATCHPAD;
    else if (addr == ADDR_W'(OFF_STAT))       sel = SEL_STAT;
    else if (addr == ADDR_W'(OFF_ERROR_MASK)) sel = SEL_ERROR_MASK;
    else if (addr == ADDR_W'(OFF_ERROR))      sel = SEL_ERROR;
    return sel;
  endfunction

  // Address and data are only taken together, and never while reset is asserted.
  assign awready   = rst_n && (w_state_q == W_IDLE) && awvalid && wvalid;
  assign wready    = awready;
  assign arready   = rst_n && (r_state_q == R_IDLE);
  assign wr_fire_c = awready;
  assign rd_fire_c = arvalid && arready;

  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign err_irq = err_irq_q;

  // Register file update; a set from err_in always wins over a W1C clear.
  always_comb begin
    scratch_d       = scratch_q;
    mask_d          = mask_q;
    stat_d          = stat_in;
    err_clr_c       = '0;
    wr_sel_c        = decode(awaddr);
    wr_misaligned_c = (awaddr[2:0] != 3'b000);
    wr_bitmask_c    = strb_to_mask(wstrb);
    if (wr_fire_c && !wr_misaligned_c) begin
      case (wr_sel_c)
        SEL_SCRATCHPAD: scratch_d = (scratch_q & ~wr_bitmask_c) | (wdata & wr_bitmask_c);
        SEL_ERROR_MASK: mask_d    = (mask_q & ~wr_bitmask_c) | (wdata & wr_bitmask_c);
        SEL_ERROR:      err_clr_c = ERR_W'(wdata & wr_bitmask_c);
        default:        ;
      endcase
    end
    error_d   = (error_q & ~err_clr_c) | (err_in & ~mask_q[ERR_W-1:0]);
    err_irq_d = |error_q;
  end

  // Write channel FSM.
  always_comb begin
    w_state_d = w_state_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_fire_c) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_misaligned_c ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read mux sees pre-write register contents.
  always_comb begin
    rd_sel_c        = decode(araddr);
    rd_misaligned_c = (araddr[2:0] != 3'b000);
    case (rd_sel_c)
      SEL_DFH:        rd_value_c = DFH_VALUE;
      SEL_SCRATCHPAD: rd_value_c = scratch_q;
      SEL_STAT:       rd_value_c = stat_q;
      SEL_ERROR_MASK: rd_value_c = mask_q;
      SEL_ERROR:      rd_value_c = 64'(error_q);
      default:        rd_value_c = '0;
    endcase
    if (rd_misaligned_c) rd_value_c = '0;
  end

  // Read channel FSM.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_fire_c) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_value_c;
          rresp_d   = rd_misaligned_c ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      scratch_q <= '0;
      stat_q    <= '0;
      mask_q    <= '0;
      error_q   <= '0;
      err_irq_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      scratch_q <= scratch_d;
      stat_q    <= stat_d;
      mask_q    <= mask_d;
      error_q   <= error_d;
      err_irq_q <= err_irq_d;
    end
  end

endmodule
